// File: rtl/time_pkg.sv
// Shared widths, default wrap points and mode encoding for the mm:ss core.
package time_pkg;

    localparam int BCD_W            = 4;
    localparam int SEC_WRAP_DEFAULT = 59;
    localparam int MIN_WRAP_DEFAULT = 59;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_ADJUST = 2'd2
    } mode_t;

    // Binary 0..99 to a packed {tens, ones} BCD pair.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(value / 10);
        ones = BCD_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter 00..WRAP with a combinational carry on the wrap step.
module bcd_pair_counter
    import time_pkg::*;
#(
    parameter int WRAP = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [BCD_W-1:0] ten,
    output logic [BCD_W-1:0] one,
    output logic             carry
);

    localparam logic [2*BCD_W-1:0] WRAP_BCD = to_bcd(WRAP);

    logic at_wrap;

    // Wrap is decided on the full two-digit value, not on either digit alone.
    assign at_wrap = ({ten, one} == WRAP_BCD);
    assign carry   = inc && at_wrap;

    // BCD increment: wrap to 00 at WRAP, otherwise ones 9->0 carries into tens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ten <= '0;
            one <= '0;
        end else if (inc) begin
            if (at_wrap) begin
                ten <= '0;
                one <= '0;
            end else if (one == BCD_W'(9)) begin
                one <= '0;
                ten <= ten + BCD_W'(1);
            end else begin
                one <= one + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmss_time_core.sv
// Minutes:seconds timekeeping core with pause toggle and per-field adjust.
module mmss_time_core
    import time_pkg::*;
#(
    parameter int MIN_WRAP = MIN_WRAP_DEFAULT,
    parameter int SEC_WRAP = SEC_WRAP_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             tick_4hz,
    input  logic             pause_btn,
    input  logic             adj,
    input  logic             sel,
    output logic [BCD_W-1:0] min_ten,
    output logic [BCD_W-1:0] min_one,
    output logic [BCD_W-1:0] sec_ten,
    output logic [BCD_W-1:0] sec_one,
    output logic             paused,
    output logic             blink,
    output logic             rollover
);

    logic  adj_q;
    logic  sel_q;
    logic  pause_prev;
    logic  pause_edge;
    mode_t mode;
    logic  adj_strobe;
    logic  sec_inc;
    logic  min_inc;
    logic  sec_carry;
    logic  min_carry;

    // Register adj/sel once; the mode decode only ever looks at these copies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adj_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            adj_q <= adj;
            sel_q <= sel;
        end
    end

    // Edge register resets high so a button held through reset does not toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pause_prev <= 1'b1;
        end else begin
            pause_prev <= pause_btn;
        end
    end

    assign pause_edge = pause_btn && !pause_prev;

    // Pause flag toggles on every rising button edge, whatever the mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paused <= 1'b0;
        end else if (pause_edge) begin
            paused <= !paused;
        end
    end

    // Mode decode: adjust beats hold, hold beats run.
    always_comb begin
        mode = MODE_RUN;
        if (adj_q) begin
            mode = MODE_ADJUST;
        end else if (paused) begin
            mode = MODE_HOLD;
        end
    end

    // In adjust the 2 Hz tick bumps only the selected field and never carries;
    // tick_1hz is simply not routed anywhere outside RUN, so it is dropped.
    assign adj_strobe = (mode == MODE_ADJUST) && tick_2hz;
    assign sec_inc    = ((mode == MODE_RUN) && tick_1hz) || (adj_strobe && sel_q);
    assign min_inc    = ((mode == MODE_RUN) && sec_carry) || (adj_strobe && !sel_q);

    bcd_pair_counter #(
        .WRAP (SEC_WRAP)
    ) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .ten   (sec_ten),
        .one   (sec_one),
        .carry (sec_carry)
    );

    bcd_pair_counter #(
        .WRAP (MIN_WRAP)
    ) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .ten   (min_ten),
        .one   (min_one),
        .carry (min_carry)
    );

    // Rollover pulses only for a counting wrap of both fields, never in adjust.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rollover <= 1'b0;
        end else begin
            rollover <= (mode == MODE_RUN) && min_carry;
        end
    end

    // Blink phase runs on 4 Hz while adjusting and clears as soon as adj drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink <= 1'b0;
        end else if (!adj) begin
            blink <= 1'b0;
        end else if ((mode == MODE_ADJUST) && tick_4hz) begin
            blink <= !blink;
        end
    end

endmodule

// File: tb/tb_mmss_time_core.sv
// Randomized and directed checks of mmss_time_core against a behavioural model.
module tb_mmss_time_core;

    localparam int MW = 59;
    localparam int SW = 59;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       tick_4hz;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
    logic       paused;
    logic       blink;
    logic       rollover;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int m_sec, m_min;
    bit m_paused, m_blink, m_roll, m_prev, m_adjq, m_selq;

    mmss_time_core #(.MIN_WRAP(MW), .SEC_WRAP(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .tick_4hz  (tick_4hz),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .min_ten   (min_ten),
        .min_one   (min_one),
        .sec_ten   (sec_ten),
        .sec_one   (sec_one),
        .paused    (paused),
        .blink     (blink),
        .rollover  (rollover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_min = 0;
        m_paused = 0; m_blink = 0; m_roll = 0;
        m_prev = 1; m_adjq = 0; m_selq = 0;
    endtask

    // One clock of the timekeeping rules, using inputs seen at the edge.
    task automatic model_update();
        bit adjusting, holding;
        adjusting = m_adjq;
        holding   = !m_adjq && m_paused;
        m_roll = 0;
        if (!adjusting && !holding && tick_1hz) begin
            if (m_sec == SW) begin
                m_sec = 0;
                if (m_min == MW) begin
                    m_min = 0;
                    m_roll = 1;
                end else begin
                    m_min = m_min + 1;
                end
            end else begin
                m_sec = m_sec + 1;
            end
        end
        if (adjusting && tick_2hz) begin
            if (m_selq) m_sec = (m_sec == SW) ? 0 : m_sec + 1;
            else        m_min = (m_min == MW) ? 0 : m_min + 1;
        end
        if (pause_btn && !m_prev) m_paused = !m_paused;
        m_prev = pause_btn;
        if (!adj) m_blink = 0;
        else if (adjusting && tick_4hz) m_blink = !m_blink;
        m_adjq = adj;
        m_selq = sel;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".min_ten"},  32'(min_ten),  32'(m_min / 10));
        chk({tag, ".min_one"},  32'(min_one),  32'(m_min % 10));
        chk({tag, ".sec_ten"},  32'(sec_ten),  32'(m_sec / 10));
        chk({tag, ".sec_one"},  32'(sec_one),  32'(m_sec % 10));
        chk({tag, ".paused"},   32'(paused),   32'(m_paused));
        chk({tag, ".blink"},    32'(blink),    32'(m_blink));
        chk({tag, ".rollover"}, 32'(rollover), 32'(m_roll));
    endtask

    task automatic step(input string tag = "cyc");
        @(posedge clk);
        if (!reset) model_reset();
        else        model_update();
        #1;
        compare_all(tag);
    endtask

    task automatic tick(input bit t1, input bit t2, input bit t4, input string tag = "tick");
        tick_1hz = t1; tick_2hz = t2; tick_4hz = t4;
        step(tag);
        tick_1hz = 0; tick_2hz = 0; tick_4hz = 0;
    endtask

    // Enter adjust and walk both fields to m:s; leaves adj=1, sel=1.
    task automatic adjust_to(input int m, input int s);
        adj = 1; sel = 0;
        step("adj_in");
        for (int i = 0; i < 120 && m_min != m; i++) tick(1'($urandom % 2), 1, 1'($urandom % 2), "adj_min");
        sel = 1;
        step("adj_sel");
        for (int i = 0; i < 120 && m_sec != s; i++) tick(1'($urandom % 2), 1, 1'($urandom % 2), "adj_sec");
        chk("adjust_to.min", 32'(m_min), 32'(m));
        chk("adjust_to.sec", 32'(m_sec), 32'(s));
    endtask

    task automatic exit_adjust();
        adj = 0;
        step("adj_out");
        chk("exit.blink", 32'(blink), 0);
    endtask

    initial begin
        reset = 0; tick_1hz = 0; tick_2hz = 0; tick_4hz = 0;
        pause_btn = 0; adj = 0; sel = 0;
        model_reset();
        #3;
        compare_all("reset_async");
        step("reset");
        step("reset");
        reset = 1;

        // 75 seconds of counting with random gaps between ticks
        repeat (75) begin
            tick(1, 0, 0, "run75");
            repeat ($urandom_range(0, 2)) step("run75_gap");
        end
        chk("run75.min_one", 32'(min_one), 1);
        chk("run75.sec_ten", 32'(sec_ten), 1);
        chk("run75.sec_one", 32'(sec_one), 5);
        chk("run75.paused",  32'(paused),  0);

        // preload 59:58 and cross the full wrap
        adjust_to(59, 58);
        exit_adjust();
        tick(1, 0, 0, "wrap_a");
        chk("wrap.5959", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h5959);
        tick(1, 0, 0, "wrap_b");
        chk("wrap.roll_hi", 32'(rollover), 1);
        chk("wrap.0000", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h0000);
        step("wrap_c");
        chk("wrap.roll_lo", 32'(rollover), 0);

        // pause freezes, second press resumes
        adjust_to(12, 34);
        exit_adjust();
        pause_btn = 1; step("pause_on"); pause_btn = 0; step("pause_on");
        repeat (10) tick(1, 0, 0, "hold");
        chk("hold.digits", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h1234);
        chk("hold.paused", 32'(paused), 1);
        pause_btn = 1; step("pause_off"); pause_btn = 0; step("pause_off");
        tick(1, 0, 0, "resume");
        chk("resume.digits", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h1235);
        chk("resume.paused", 32'(paused), 0);

        // seconds adjust wraps without carry; then minutes; then blink
        adjust_to(0, 58);
        repeat (3) tick(0, 1, 0, "adj_s");
        chk("adj_s.digits", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h0001);
        sel = 0; step("adj_sel0");
        repeat (2) tick(0, 1, 0, "adj_m");
        chk("adj_m.digits", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h0201);
        begin
            logic b0;
            b0 = blink;
            tick(0, 0, 1, "blink1");
            chk("blink.t1", 32'(blink), 32'(!b0));
            repeat (3) tick(0, 0, 1, "blink");
            chk("blink.t4", 32'(blink), 32'(b0));
        end
        tick(0, 0, 1, "blink_odd");
        exit_adjust();

        // simultaneous 1 Hz and 2 Hz while adjusting seconds
        adjust_to(0, 10);
        tick(1, 1, 0, "both");
        chk("both.digits", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h0011);
        exit_adjust();

        // randomized free run
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) adj = !adj;
            if ($urandom_range(0, 7) == 0) sel = !sel;
            if ($urandom_range(0, 29) == 0) pause_btn = !pause_btn;
            tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) == 0), "rand");
        end
        adj = 0; sel = 0; pause_btn = 0;
        step("rand_end");
        if (m_paused) begin
            pause_btn = 1; step("unpause"); pause_btn = 0; step("unpause");
        end

        // button held through reset release must not toggle
        pause_btn = 1; reset = 0;
        step("rst_hold"); step("rst_hold");
        reset = 1;
        repeat (3) step("rst_rel");
        chk("rst_hold.paused", 32'(paused), 0);
        pause_btn = 0;

        // asynchronous clear mid-count at 03:07
        adjust_to(3, 7);
        exit_adjust();
        step("pre_async");
        chk("pre_async.digits", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h0307);
        #2 reset = 0;
        #1;
        chk("async.digits", 32'({min_ten, min_one, sec_ten, sec_one}), 32'h0000);
        chk("async.paused", 32'(paused), 0);
        chk("async.rollover", 32'(rollover), 0);
        step("async_hold");
        reset = 1;
        repeat (5) tick(1, 0, 0, "post_async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmss_time_core.md
Name: mmss_time_core

Overview:
- Minutes:seconds timekeeping core; produces the four BCD digits that the seven-segment multiplexer consumes.
- Consumes single-cycle enable ticks from the shared dividers and debounced button levels, all on the system clock. No derived clocks are used.
- Implements normal counting, a pause toggle, and an adjust mode for the selected field (minutes or seconds).

Parameters:
- MIN_WRAP, 59, last minute value before wrapping to 00 (legal 1..99)
- SEC_WRAP, 59, last second value before wrapping to 00 (legal 1..99)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (reset=0 clears state)
- tick_1hz  input  1  one-cycle pulse, count rate
- tick_2hz  input  1  one-cycle pulse, adjust rate
- tick_4hz  input  1  one-cycle pulse, blink rate
- pause_btn  input  1  debounced pause button level
- adj  input  1  adjust-mode level (1=adjust)
- sel  input  1  adjust field select (0=minutes, 1=seconds)
- min_ten  output  4  BCD minutes tens
- min_one  output  4  BCD minutes ones
- sec_ten  output  4  BCD seconds tens
- sec_one  output  4  BCD seconds ones
- paused  output  1  pause flag
- blink  output  1  display blank request for the field being adjusted
- rollover  output  1  one-cycle pulse on wrap from MIN_WRAP:SEC_WRAP to 00:00

Behaviour:
- Reset values: all digits 0; paused=0; blink=0; rollover=0; pause edge register=1, so a button already held at reset release does not toggle.
- All outputs are registered. A digit changes on the clk edge that samples its tick; latency is 1 cycle.
- Pause:
  - A rising edge on pause_btn (registered previous value compared with current) toggles paused.
  - The toggle is accepted in every mode.
- Mode decode, priority order:
  1. ADJUST when adj=1.
  2. HOLD when paused=1.
  3. RUN otherwise.
- RUN:
  - On tick_1hz, seconds increment in BCD.
  - When seconds=SEC_WRAP, seconds go to 00 and minutes increment.
  - When minutes=MIN_WRAP as well, minutes go to 00 and rollover pulses for 1 cycle.
- HOLD:
  - tick_1hz is ignored; digits are frozen.
  - tick_1hz pulses are dropped, not accumulated.
- ADJUST:
  - tick_1hz is ignored.
  - On tick_2hz, the selected field increments by 1 and wraps at its WRAP value to 00 with no carry into the other field. rollover stays 0.
  - sel may change at any time; it is sampled on the tick_2hz cycle.
  - blink toggles on each tick_4hz while in ADJUST. blink is forced to 0 on the first cycle adj=0.
- Simultaneous events:
  - tick_1hz and tick_2hz together in ADJUST: adjust only.
  - tick_1hz together with the pause edge in RUN: the increment happens and paused sets on the same edge.
  - adj falling on a tick_1hz cycle: mode is evaluated from the registered adj, so the tick belongs to ADJUST and is ignored.
- Input registration: adj and sel are each registered once inside the block; mode uses the registered copies.
- BCD arithmetic:
  - The ones digit wraps from 9 to 0 and increments the tens digit.
  - The wrap comparison is on the full two-digit value.
  - Values above WRAP are unreachable.
- Reset mid-operation: asynchronous clear to the reset values, including the paused flag and the blink phase.

Decomposition:
- Shared package time_pkg holds:
  - BCD_W=4
  - SEC_WRAP_DEFAULT=59
  - MIN_WRAP_DEFAULT=59
  - mode encoding: RUN=2'd0, HOLD=2'd1, ADJUST=2'd2
- One sub-module, bcd_pair_counter, instantiated twice (seconds, minutes):
  - Parameter WRAP.
  - Inputs clk, reset, inc.
  - Outputs ten[3:0], one[3:0], and combinational carry (inc && value==WRAP).
- The minutes inc is the seconds carry in RUN, or the adjust strobe in ADJUST.

Test Plan:
- Reset, then 75 tick_1hz pulses in RUN -> digits 01:15, paused=0, rollover never asserted.
- Preload to 59:58 via adjust, then 2 tick_1hz -> 59:59 then 00:00; rollover high for exactly 1 cycle on the wrap edge.
- At 12:34, pause_btn pulse, then 10 tick_1hz -> stays 12:34, paused=1; second pause_btn pulse, then 1 tick_1hz -> 12:35, paused=0.
- adj=1, sel=1 at 00:58, then 3 tick_2hz -> 00:59, 00:00, 00:01 (minutes unchanged); sel=0, then 2 tick_2hz -> 02:01; 4 tick_4hz -> blink toggles 4 times; adj=0 -> blink=0 next cycle.
- tick_1hz and tick_2hz in the same cycle with adj=1, sel=1 at 00:10 -> 00:11 (single increment).
- pause_btn held high through reset release -> paused stays 0; assert reset=0 mid-count at 03:07 -> outputs 00:00 immediately, without waiting for a clk edge.
